// File: rtl/seq_divider_16_by_8.sv
// -----------------------------------------------------------------------------
// seq_divider_16_by_8
//   Sequential restoring divider: unsigned DW-bit dividend / VW-bit divisor.
//   One quotient bit per clock, fixed latency for every operand
//   (divide-by-zero included).
//
// Handshake (valid/ready style):
//   start is the request; it is accepted on a rising edge only while busy=0
//   (FSM in IDLE). A start seen while busy=1 is dropped, not queued.
//   For a start accepted at edge N, busy is high after edges N..N+DW and done
//   is a one-cycle pulse after edge N+DW+1 (busy=0 in that cycle). Results
//   become valid with done and hold until the next done or reset. Because the
//   FSM is back in IDLE while done=1, a start held in that cycle is accepted at
//   the very next edge.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only when busy=0
//   dividend     DW-bit unsigned dividend, captured on accept
//   divisor      VW-bit unsigned divisor, captured on accept
//   busy         operation in progress
//   done         one-cycle completion pulse
//   quotient     DW-bit quotient (all ones on divide-by-zero)
//   remainder    VW-bit remainder (dividend[VW-1:0] on divide-by-zero)
//   div_by_zero  set with done when the captured divisor was 0
//   dbg_state    current FSM state (IDLE=0, CALC=1, DONE=2)
// -----------------------------------------------------------------------------
module seq_divider_16_by_8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(DW + 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  // Dividend shift register; quotient bits are shifted in at its LSB end, so
  // after DW iterations it holds the quotient.
  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_divisor;
  logic [VW:0]   r_prem;
  logic [VW-1:0] r_dvd_lo;
  logic          r_dz;
  logic          r_done;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem;
  logic          r_dz_out;

  logic [VW:0]   w_shift;
  logic [VW:0]   w_trial;
  logic          w_fits;

  // After a restore the partial remainder is below the divisor, so its top bit
  // is zero and only the low VW bits need to be carried into the shift.
  assign w_shift = {r_prem[VW-1:0], r_dvd[DW-1]};
  assign w_trial = w_shift - {1'b0, r_divisor};
  assign w_fits  = ~w_trial[VW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_divisor <= '0;
      r_prem    <= '0;
      r_dvd_lo  <= '0;
      r_dz      <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dz_out  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd     <= dividend;
            r_divisor <= divisor;
            r_dvd_lo  <= dividend[VW-1:0];
            r_dz      <= (divisor == '0);
            r_prem    <= '0;
            r_cnt     <= CW'(DW);
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_prem  <= w_fits ? w_trial : w_shift;
          r_dvd   <= {r_dvd[DW-2:0], w_fits};
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_dz_out <= r_dz;
          // A zero divisor still runs the full iteration so latency is
          // constant; the result is then overridden with the defined values.
          if (r_dz) begin
            r_quot <= '1;
            r_rem  <= r_dvd_lo;
          end else begin
            r_quot <= r_dvd;
            r_rem  <= r_prem[VW-1:0];
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz_out;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_divider_16_by_8.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_16_by_8
//   Self-checking bench for seq_divider_16_by_8. A reference model predicts
//   acceptance from the request protocol alone, pushes the expected result to
//   a queue and checks done/busy timing every cycle; results are popped and
//   compared when done pulses.
// -----------------------------------------------------------------------------
module tb_seq_divider_16_by_8;

  localparam int DW = 16;
  localparam int VW = 8;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  seq_divider_16_by_8 #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ----------------------------------------------------------------- checking
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  // exp_q entry: {div_by_zero, quotient, remainder}; op_q entry: {dividend, divisor}
  logic [DW+VW:0]  exp_q[$];
  logic [DW+VW-1:0] op_q[$];
  int last_acc = -100;   // edge index of the last accepted start

  function automatic logic [DW+VW:0] model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    if (b == '0) return {1'b1, {DW{1'b1}}, a[VW-1:0]};
    q = a / DW'(b);
    r = a % DW'(b);
    return {1'b0, q, r[VW-1:0]};
  endfunction

  always @(negedge clk) begin
    logic [DW+VW:0]   e;
    logic [DW+VW-1:0] o;
    logic [31:0]      lhs;
    if (rst_n) begin
      check("done", {31'b0, done}, {31'b0, (cyc == last_acc + DW + 1)});
      check("busy", {31'b0, busy}, {31'b0, (cyc >= last_acc) && (cyc <= last_acc + DW)});
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          o = op_q.pop_front();
          check("quotient", {16'b0, quotient}, {16'b0, e[DW+VW-1:VW]});
          check("remainder", {24'b0, remainder}, {24'b0, e[VW-1:0]});
          check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e[DW+VW]});
          if (o[VW-1:0] != '0) begin
            lhs = 32'(quotient) * 32'(o[VW-1:0]) + 32'(remainder);
            check("invariant", lhs, 32'(o[DW+VW-1:VW]));
            check("rem_lt_divisor", {31'b0, remainder < o[VW-1:0]}, 32'd1);
          end
        end
      end
      // Next edge is cyc+1; the model is idle again DW+2 edges after an accept.
      if (start && (cyc + 1 >= last_acc + DW + 2)) begin
        last_acc = cyc + 1;
        exp_q.push_back(model(dividend, divisor));
        op_q.push_back({dividend, divisor});
      end
    end
  end

  // ------------------------------------------------------------------ drivers
  task automatic apply(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int waited;
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    waited   = 0;
    while (last_acc != cyc && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    start = 1'b0;
    if (last_acc != cyc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_quotient"}, {16'b0, quotient}, 32'd0);
    check({tag, "_remainder"}, {24'b0, remainder}, 32'd0);
    check({tag, "_dz"}, {31'b0, div_by_zero}, 32'd0);
    check({tag, "_state"}, {30'b0, dbg_state}, 32'd0);
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic divide and boundary operands
    apply(16'd1000, 8'd7);    wait_done();
    apply(16'd65535, 8'd255); wait_done();
    apply(16'd100, 8'd200);   wait_done();
    apply(16'd0, 8'd5);       wait_done();
    apply(16'd65535, 8'd1);   wait_done();

    // Divide by zero, then a normal divide clears the flag
    apply(16'h1234, 8'd0);    wait_done();
    apply(16'd10, 8'd3);      wait_done();

    // start pulsed during CALC with other operands is ignored
    apply(16'd1000, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    dividend = 16'd500;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // start held high across done: back-to-back operations
    @(posedge clk); #1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dividend = 16'd300;
    divisor  = 8'd4;
    repeat (40) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Reset during iteration 8 of 40000/123
    apply(16'd40000, 8'd123);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    last_acc = -100;
    exp_q.delete();
    op_q.delete();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    apply(16'd40000, 8'd123); wait_done();

    // Random sweep, back-to-back, non-zero divisor
    for (int i = 0; i < 2000; i++) begin
      apply(DW'($urandom_range(0, 65535)), VW'($urandom_range(1, 255)));
    end
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
